// File: rtl/dma_wdata_streamer.sv
// Drains the DMA data FIFO through a 2-entry prefetch buffer and emits it as a
// burst-framed write-data stream; the buffer hides the one-cycle FIFO read latency.
`timescale 1ns/1ps
module dma_wdata_streamer #(
   parameter int DMA_DATA_WIDTH = 512,
   parameter int WIDTH          = DMA_DATA_WIDTH,
   parameter int LEN_W          = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clear_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [LEN_W-1:0] cmd_len_i,
   input  logic             fifo_empty_i,
   output logic             fifo_rd_o,
   input  logic [WIDTH-1:0] fifo_data_i,
   output logic             wvalid_o,
   input  logic             wready_i,
   output logic [WIDTH-1:0] wdata_o,
   output logic             wlast_o,
   output logic             busy_o,
   output logic             dbg_state
);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t           state;
   logic [LEN_W-1:0] beat_cnt;
   logic [WIDTH-1:0] buf_q [2];
   logic [1:0]       cnt;
   logic             inflight;
   logic             pop;
   logic [1:0]       cnt_after_pop;
   logic [2:0]       occ_next;

   // Handshakes: a transfer happens in a cycle where valid and ready are both
   // high; once wvalid_o is up, wvalid_o/wdata_o/wlast_o hold until wready_i.
   assign wvalid_o    = (state == BURST) && (cnt != 2'd0);
   assign wdata_o     = buf_q[0];
   assign wlast_o     = wvalid_o && (beat_cnt == '0);
   assign cmd_ready_o = (state == IDLE);
   assign busy_o      = (state == BURST);
   assign dbg_state   = (state == BURST);

   assign pop           = wvalid_o && wready_i;
   assign cnt_after_pop = cnt - {1'b0, pop};
   // Occupancy after this cycle's pop plus the datum already on its way back.
   assign occ_next      = {1'b0, cnt_after_pop} + {2'b00, inflight};
   assign fifo_rd_o     = !fifo_empty_i && !clear_i && (occ_next < 3'd2);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         beat_cnt <= '0;
      end else if (clear_i) begin
         state    <= IDLE;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  beat_cnt <= cmd_len_i;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (pop) begin
                  if (wlast_o) state <= IDLE;
                  else         beat_cnt <= beat_cnt - LEN_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt      <= 2'd0;
         inflight <= 1'b0;
         buf_q[0] <= '0;
         buf_q[1] <= '0;
      end else if (clear_i) begin
         // Data returning this cycle belongs to the flushed FIFO contents.
         cnt      <= 2'd0;
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd_o;
         if (pop) buf_q[0] <= buf_q[1];
         if (inflight) begin
            if (cnt_after_pop == 2'd0) buf_q[0] <= fifo_data_i;
            else                       buf_q[1] <= fifo_data_i;
         end
         cnt <= cnt_after_pop + {1'b0, inflight};
      end
   end

   a_occ_max: assert property (@(posedge clk) disable iff (!rstn) occ_next <= 3'd2);

endmodule

// File: tb/tb_dma_wdata_streamer.sv
// Directed bench for dma_wdata_streamer: a table of per-cycle vectors for the
// single-beat and full-rate bursts, then hand-written multi-cycle corner cases.
`timescale 1ns/1ps
module tb_dma_wdata_streamer;
   localparam int W  = 512;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rstn, clear_i, cmd_valid_i, cmd_ready_o;
   logic [LW-1:0] cmd_len_i;
   logic          fifo_empty_i, fifo_rd_o;
   logic [W-1:0]  fifo_data_i, wdata_o;
   logic          wvalid_o, wready_i, wlast_o, busy_o, dbg_state;

   dma_wdata_streamer #(.DMA_DATA_WIDTH(W), .WIDTH(W), .LEN_W(LW)) dut (
      .clk(clk), .rstn(rstn), .clear_i(clear_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
      .fifo_empty_i(fifo_empty_i), .fifo_rd_o(fifo_rd_o), .fifo_data_i(fifo_data_i),
      .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wlast_o(wlast_o),
      .busy_o(busy_o), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int rd_count = 0;

   logic [W:0]   exp_q [$];
   logic [W-1:0] stage_q [$];
   logic [W-1:0] fifo_q [$];

   task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // FIFO model: words staged by the stimulus become visible one edge later.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fifo_q.delete();
         fifo_data_i  <= '0;
         fifo_empty_i <= 1'b1;
      end else begin
         if (clear_i) fifo_q.delete();
         else if (fifo_rd_o) fifo_data_i <= fifo_q.pop_front();
         while (stage_q.size() > 0) fifo_q.push_back(stage_q.pop_front());
         fifo_empty_i <= (fifo_q.size() == 0);
      end
   end

   logic         prev_stall = 1'b0;
   logic         prev_clear = 1'b0;
   logic         prev_last  = 1'b0;
   logic [W-1:0] prev_data  = '0;

   always @(negedge clk) begin
      logic [W:0] e;
      if (rstn) begin
         if (fifo_rd_o) rd_count++;
         if (wvalid_o) chk("wvalid_only_in_burst", {{W{1'b0}}, busy_o}, 1);
         if (prev_stall && !prev_clear) begin
            chk("hold_wvalid", {{W{1'b0}}, wvalid_o}, 1);
            chk("hold_wdata", {1'b0, wdata_o}, {1'b0, prev_data});
            chk("hold_wlast", {{W{1'b0}}, wlast_o}, {{W{1'b0}}, prev_last});
         end
         if (wvalid_o && wready_i) begin
            if (exp_q.size() == 0) chk("unexpected_beat", {1'b0, wdata_o}, '1);
            else begin
               e = exp_q.pop_front();
               chk("beat_data", {1'b0, wdata_o}, {1'b0, e[W-1:0]});
               chk("beat_last", {{W{1'b0}}, wlast_o}, {{W{1'b0}}, e[W]});
            end
         end
         prev_stall = wvalid_o && !wready_i;
         prev_clear = clear_i;
         prev_data  = wdata_o;
         prev_last  = wlast_o;
      end else begin
         prev_stall = 1'b0;
      end
   end

   typedef struct {
      logic          cmd_valid;
      logic [LW-1:0] cmd_len;
      logic          wready;
      logic          e_cmd_ready;
      logic          e_rd;
      logic          e_wvalid;
      logic          e_wlast;
      logic          e_busy;
      int            e_idx;
   } vec_t;

   vec_t         vecs [13];
   logic [W-1:0] words [9];
   logic         pat [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cmd_valid_i = 1'b0;
      cmd_len_i   = '0;
      wready_i    = 1'b0;
      clear_i     = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, {{W{1'b0}}, cmd_ready_o}, 1);
      chk({tag, "_fifo_rd"},   {{W{1'b0}}, fifo_rd_o},   0);
      chk({tag, "_wvalid"},    {{W{1'b0}}, wvalid_o},    0);
      chk({tag, "_wlast"},     {{W{1'b0}}, wlast_o},     0);
      chk({tag, "_wdata"},     {1'b0, wdata_o},          0);
      chk({tag, "_busy"},      {{W{1'b0}}, busy_o},      0);
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int r = lo; r <= hi; r++) begin
         cmd_valid_i = vecs[r].cmd_valid;
         cmd_len_i   = vecs[r].cmd_len;
         wready_i    = vecs[r].wready;
         clear_i     = 1'b0;
         @(negedge clk);
         chk($sformatf("vec%0d_cmd_ready", r), {{W{1'b0}}, cmd_ready_o}, {{W{1'b0}}, vecs[r].e_cmd_ready});
         chk($sformatf("vec%0d_fifo_rd", r),   {{W{1'b0}}, fifo_rd_o},   {{W{1'b0}}, vecs[r].e_rd});
         chk($sformatf("vec%0d_wvalid", r),    {{W{1'b0}}, wvalid_o},    {{W{1'b0}}, vecs[r].e_wvalid});
         chk($sformatf("vec%0d_wlast", r),     {{W{1'b0}}, wlast_o},     {{W{1'b0}}, vecs[r].e_wlast});
         chk($sformatf("vec%0d_busy", r),      {{W{1'b0}}, busy_o},      {{W{1'b0}}, vecs[r].e_busy});
         if (vecs[r].e_idx >= 0)
            chk($sformatf("vec%0d_wdata", r), {1'b0, wdata_o}, {1'b0, words[vecs[r].e_idx]});
         tick();
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         done = !busy_o;
         tick();
      end
      chk({tag, "_finished"}, {{W{1'b0}}, done}, 1);
      chk({tag, "_all_beats"}, exp_q.size(), 0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic done;
      words[0] = {64{8'hA5}};
      for (int i = 1; i < 9; i++) words[i] = {16{32'hD000_0000 + 32'(i)}};
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

      // Single beat (rows 0-2), then 8-beat full-rate burst (rows 3-12).
      vecs[0]  = '{1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1};
      vecs[1]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,  0};
      vecs[2]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1};
      vecs[3]  = '{1'b1, 8'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1};
      for (int k = 1; k <= 6; k++)
         vecs[3+k] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, k};
      vecs[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  7};
      vecs[11] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,  8};
      vecs[12] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1};

      rstn = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      tick();
      rstn = 1'b1;
      repeat (2) tick();

      stage_q.push_back(words[0]);
      exp_q.push_back({1'b1, words[0]});
      repeat (4) tick();
      run_rows(0, 2);

      idle_inputs();
      rd_count = 0;
      for (int i = 1; i <= 8; i++) begin
         stage_q.push_back(words[i]);
         exp_q.push_back({(i == 8), words[i]});
      end
      repeat (5) tick();
      run_rows(3, 12);
      chk("full_rate_pops", rd_count, 8);

      // Backpressure: 4-beat burst with wready 1,0,0,1 repeating.
      idle_inputs();
      rd_count = 0;
      for (int i = 0; i < 4; i++) begin
         stage_q.push_back({16{32'hE000_0000 + 32'(i)}});
         exp_q.push_back({(i == 3), {16{32'hE000_0000 + 32'(i)}}});
      end
      repeat (5) tick();
      cmd_valid_i = 1'b1;
      cmd_len_i   = 8'd3;
      @(negedge clk);
      tick();
      cmd_valid_i = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         wready_i = pat[i % 4];
         @(negedge clk);
         done = !busy_o;
         tick();
      end
      chk("bp_finished", {{W{1'b0}}, done}, 1);
      chk("bp_all_beats", exp_q.size(), 0);
      chk("bp_pops", rd_count, 4);

      // Starvation: one word buffered, two more arrive after a gap.
      idle_inputs();
      stage_q.push_back({16{32'h5000_0000}});
      for (int i = 0; i < 3; i++) exp_q.push_back({(i == 2), {16{32'h5000_0000 + 32'(i)}}});
      repeat (5) tick();
      cmd_valid_i = 1'b1;
      cmd_len_i   = 8'd2;
      wready_i    = 1'b1;
      @(negedge clk);
      tick();
      cmd_valid_i = 1'b0;
      @(negedge clk);
      tick();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("starve_gap_wvalid", {{W{1'b0}}, wvalid_o}, 0);
         chk("starve_gap_busy", {{W{1'b0}}, busy_o}, 1);
         tick();
      end
      stage_q.push_back({16{32'h5000_0001}});
      stage_q.push_back({16{32'h5000_0002}});
      wait_idle("starve", 20);

      // Clear the cycle after a pop; the returning datum and queued word are dropped.
      idle_inputs();
      cmd_valid_i = 1'b1;
      cmd_len_i   = 8'd3;
      stage_q.push_back({16{32'hBAD0_0000}});
      stage_q.push_back({16{32'hBAD0_0001}});
      @(negedge clk);
      tick();
      cmd_valid_i = 1'b0;
      @(negedge clk);
      chk("clr_pop_before", {{W{1'b0}}, fifo_rd_o}, 1);
      tick();
      clear_i     = 1'b1;
      wready_i    = 1'b1;
      cmd_valid_i = 1'b1;
      cmd_len_i   = 8'd0;
      @(negedge clk);
      chk("clr_fifo_rd_forced", {{W{1'b0}}, fifo_rd_o}, 0);
      tick();
      idle_inputs();
      @(negedge clk);
      chk("clr_busy", {{W{1'b0}}, busy_o}, 0);
      chk("clr_wvalid", {{W{1'b0}}, wvalid_o}, 0);
      chk("clr_cmd_ready", {{W{1'b0}}, cmd_ready_o}, 1);
      chk("clr_fifo_rd", {{W{1'b0}}, fifo_rd_o}, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("clr_idle_wvalid", {{W{1'b0}}, wvalid_o}, 0);
         tick();
      end
      stage_q.push_back({16{32'hC0DE_0000}});
      exp_q.push_back({1'b1, {16{32'hC0DE_0000}}});
      cmd_valid_i = 1'b1;
      cmd_len_i   = 8'd0;
      wready_i    = 1'b1;
      @(negedge clk);
      tick();
      cmd_valid_i = 1'b0;
      wait_idle("clr_new_burst", 20);

      // Reset during beat 2 of a 4-beat burst.
      idle_inputs();
      for (int i = 0; i < 4; i++) stage_q.push_back({16{32'h7000_0000 + 32'(i)}});
      exp_q.push_back({1'b0, {16{32'h7000_0000}}});
      repeat (5) tick();
      cmd_valid_i = 1'b1;
      cmd_len_i   = 8'd3;
      wready_i    = 1'b1;
      @(negedge clk);
      tick();
      cmd_valid_i = 1'b0;
      @(negedge clk);
      tick();
      rstn = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      chk("rst_mid_beats", exp_q.size(), 0);
      idle_inputs();
      repeat (2) tick();
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_after_cmd_ready", {{W{1'b0}}, cmd_ready_o}, 1);
         chk("rst_after_wvalid", {{W{1'b0}}, wvalid_o}, 0);
         chk("rst_after_busy", {{W{1'b0}}, busy_o}, 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
